// File: rtl/av_master_arbiter_pkg.sv
// av_arb_pkg: shared types and constants for the Avalon-MM write master arbiter.
//   arb_state_t     : arbiter FSM state (IDLE, BUSY)
//   AV_ARB_MAX_REQ  : largest supported requester count
//   AV_ARB_IDX_W    : width of requester indices (grant_idx, round-robin pointer)
//   wrap_inc()      : index + 1 modulo the requester count
package av_arb_pkg;

  localparam int AV_ARB_MAX_REQ = 8;
  localparam int AV_ARB_IDX_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [AV_ARB_IDX_W-1:0] wrap_inc(
    input logic [AV_ARB_IDX_W-1:0] idx,
    input int unsigned             n
  );
    return (idx == AV_ARB_IDX_W'(n - 1)) ? '0 : idx + AV_ARB_IDX_W'(1);
  endfunction

endpackage

// File: rtl/av_master_arbiter_pick.sv
// rr_priority_pick: combinational round-robin picker.
//   req   in  NUM_REQ       request vector
//   ptr   in  AV_ARB_IDX_W  highest-priority index this round (< NUM_REQ)
//   valid out 1             any request pending
//   idx   out AV_ARB_IDX_W  first requesting index at or after ptr, wrapping
module rr_priority_pick
  import av_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]      req,
  input  logic [AV_ARB_IDX_W-1:0] ptr,
  output logic                    valid,
  output logic [AV_ARB_IDX_W-1:0] idx
);

  localparam logic [AV_ARB_IDX_W:0] NREQ = (AV_ARB_IDX_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0]  dbl;
  logic [NUM_REQ-1:0]    rot;
  logic [AV_ARB_IDX_W:0] sum;

  // Rotate the requests so bit 0 is the ptr position; the lowest set bit of
  // the rotated vector is the winner, offset back by ptr modulo NUM_REQ.
  always_comb begin
    dbl   = {req, req};
    rot   = NUM_REQ'(dbl >> ptr);
    sum   = '0;
    valid = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, ptr} + (AV_ARB_IDX_W+1)'(k);
    end
    if (sum >= NREQ) sum = sum - NREQ;
    idx = sum[AV_ARB_IDX_W-1:0];
  end

endmodule

// File: rtl/av_master_arbiter.sv
// av_master_arbiter: round-robin arbiter sharing one Avalon-MM write master
// among NUM_REQ requesters, each seeing a slave-style port with waitrequest.
// Optional watchdog: define AV_ARB_TIMEOUT_EN to abort transfers on a hung slave.
// Ports:
//   sysclk, sysreset_n       clock, synchronous active-low reset
//   req_address/writedata    flat per-requester buses, requester i in slice i
//   req_write                per-requester write request
//   req_waitrequest          per-requester stall (combinational from av_waitrequest)
//   av_address/writedata     registered master address/data (held during transfer)
//   av_write                 registered master write strobe
//   av_waitrequest           slave stall
//   busy                     arbiter in BUSY
//   grant_idx                current or last granted requester
//   timeout_err, timeout_clr sticky watchdog flag and its clear
module av_master_arbiter
  import av_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          sysclk,
  input  logic                          sysreset_n,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_writedata,
  input  logic [NUM_REQ-1:0]            req_write,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [ADDR_WIDTH-1:0]         av_address,
  output logic [DATA_WIDTH-1:0]         av_writedata,
  output logic                          av_write,
  input  logic                          av_waitrequest,
  output logic                          busy,
  output logic [AV_ARB_IDX_W-1:0]       grant_idx,
  output logic                          timeout_err,
  input  logic                          timeout_clr
);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_v;
  assign addr_v = req_address;
  assign data_v = req_writedata;

  arb_state_t                state, state_nxt;
  logic [AV_ARB_IDX_W-1:0]   ptr, win_idx;
  logic                      win_vld, grant, done, abort;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_write),
    .ptr   (ptr),
    .valid (win_vld),
    .idx   (win_idx)
  );

  assign grant = (state == IDLE) && win_vld;
  assign done  = (state == BUSY) && av_write && !av_waitrequest;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == AV_ARB_IDX_W'(k)) begin
        sel_addr = addr_v[k];
        sel_data = data_v[k];
      end
    end
  end

  // FSM
  always_ff @(posedge sysclk) begin
    if (!sysreset_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (win_vld)       state_nxt = BUSY;
      BUSY: if (done || abort) state_nxt = IDLE;
    endcase
  end

  // Master port and round-robin pointer. Address/data are only loaded on a
  // grant, so they stay frozen even if the requester changes its inputs.
  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      av_address   <= '0;
      av_writedata <= '0;
      av_write     <= 1'b0;
      grant_idx    <= '0;
      ptr          <= '0;
    end else if (grant) begin
      av_address   <= sel_addr;
      av_writedata <= sel_data;
      av_write     <= 1'b1;
      grant_idx    <= win_idx;
    end else if (done || abort) begin
      av_write     <= 1'b0;
      ptr          <= wrap_inc(grant_idx, NUM_REQ);
    end
  end

  assign busy = (state == BUSY);

  // The granted requester is released in the cycle the slave accepts, or in
  // the watchdog abort cycle so it does not stay blocked on a dead slave.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wr
    assign req_waitrequest[i] = req_write[i] &
      ~(busy & (grant_idx == AV_ARB_IDX_W'(i)) & (~av_waitrequest | abort));
  end

`ifdef AV_ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_err_q;

  // to_cnt counts stalled BUSY cycles already seen; the cycle that would make
  // it reach TIMEOUT_CYCLES is the abort cycle.
  assign abort = (state == BUSY) && av_waitrequest && (to_cnt == TO_LAST);

  always_ff @(posedge sysclk) begin
    if (!sysreset_n)                             to_cnt <= '0;
    else if (grant)                              to_cnt <= '0;
    else if ((state == BUSY) && av_waitrequest)  to_cnt <= to_cnt + TO_W'(1);
  end

  // Set has priority over clear on the same edge.
  always_ff @(posedge sysclk) begin
    if (!sysreset_n)      to_err_q <= 1'b0;
    else if (abort)       to_err_q <= 1'b1;
    else if (timeout_clr) to_err_q <= 1'b0;
  end

  assign timeout_err = to_err_q;
`else
  logic unused_to;
  assign unused_to   = timeout_clr | (TIMEOUT_CYCLES == 0);
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_av_master_arbiter.sv
// Testbench for av_master_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_av_master_arbiter;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 16;
`ifdef AV_ARB_TIMEOUT_EN
  localparam int TO = 10;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TO = 255;
  localparam bit TO_ON = 1'b0;
`endif

  logic             sysclk = 1'b0;
  logic             sysreset_n;
  logic [NR*AW-1:0] req_address;
  logic [NR*DW-1:0] req_writedata;
  logic [NR-1:0]    req_write;
  logic [NR-1:0]    req_waitrequest;
  logic [AW-1:0]    av_address;
  logic [DW-1:0]    av_writedata;
  logic             av_write;
  logic             av_waitrequest;
  logic             busy;
  logic [2:0]       grant_idx;
  logic             timeout_err;
  logic             timeout_clr;

  av_master_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .sysclk(sysclk), .sysreset_n(sysreset_n),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_write(req_write), .req_waitrequest(req_waitrequest),
    .av_address(av_address), .av_writedata(av_writedata), .av_write(av_write),
    .av_waitrequest(av_waitrequest), .busy(busy), .grant_idx(grant_idx),
    .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one transfer in flight or none.
  bit          m_ok = 1'b0;
  bit          m_busy;
  int          m_grant, m_ptr, m_stall;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit          m_err;

  function automatic bit exp_abort();
    return TO_ON && m_busy && av_waitrequest && (m_stall + 1 == TO);
  endfunction

  always @(posedge sysclk) begin
    bit ab, fnd;
    int c;
    if (!sysreset_n) begin
      m_busy = 0; m_grant = 0; m_ptr = 0; m_stall = 0;
      m_addr = '0; m_data = '0; m_err = 0; m_ok = 1;
    end else if (m_ok) begin
      ab = exp_abort();
      if (TO_ON && timeout_clr) m_err = 0;
      if (!m_busy) begin
        fnd = 0;
        for (int k = 0; k < NR; k++) begin
          c = (m_ptr + k) % NR;
          if (!fnd && req_write[c]) begin
            fnd = 1; m_busy = 1; m_grant = c; m_stall = 0;
            m_addr = req_address[c*AW +: AW];
            m_data = req_writedata[c*DW +: DW];
          end
        end
      end else if (!av_waitrequest || ab) begin
        m_busy = 0;
        m_ptr  = (m_grant + 1) % NR;
        if (ab) m_err = 1;
      end else begin
        m_stall++;
      end
    end
  end

  // Compare process: inputs are stable between posedge+1 and the next posedge.
  always @(negedge sysclk) begin
    logic [NR-1:0] ew;
    if (m_ok) begin
      for (int i = 0; i < NR; i++)
        ew[i] = req_write[i] && !(m_busy && m_grant == i && (!av_waitrequest || exp_abort()));
      chk("av_write",        32'(av_write),        32'(m_busy));
      chk("busy",            32'(busy),            32'(m_busy));
      chk("grant_idx",       32'(grant_idx),       32'(m_grant));
      chk("av_address",      32'(av_address),      32'(m_addr));
      chk("av_writedata",    32'(av_writedata),    32'(m_data));
      chk("timeout_err",     32'(timeout_err),     32'(m_err));
      chk("req_waitrequest", 32'(req_waitrequest), 32'(ew));
    end
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_address[i*AW +: AW]   = a;
    req_writedata[i*DW +: DW] = d;
  endtask

  initial begin
    int n, stall_run;
    int exp_g [4] = '{1, 0, 1, 0};
    sysreset_n = 0; req_address = '0; req_writedata = '0; req_write = '0;
    av_waitrequest = 0; timeout_clr = 0;
    repeat (3) step();
    chk("rst av_write", 32'(av_write), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst grant_idx", 32'(grant_idx), 0);
    chk("rst av_address", 32'(av_address), 0);
    chk("rst timeout_err", 32'(timeout_err), 0);
    sysreset_n = 1;
    step();

    // Single request, zero wait states
    set_req(0, 16'h0040, 16'hBEEF);
    req_write = 3'b001;
    step();
    chk("single av_write", 32'(av_write), 1);
    chk("single av_address", 32'(av_address), 32'h0040);
    chk("single av_writedata", 32'(av_writedata), 32'hBEEF);
    chk("single waitreq0", 32'(req_waitrequest[0]), 0);
    req_write = 3'b000;
    step();
    chk("single done av_write", 32'(av_write), 0);
    chk("single done busy", 32'(busy), 0);

    // Contention: ptr is now 1, so requester 1 wins first, then alternate
    set_req(1, 16'h0101, 16'h1111);
    req_write = 3'b011;
    step();
    for (int t = 0; t < 4; t++) begin
      chk("contend av_write", 32'(av_write), 1);
      chk("contend grant", 32'(grant_idx), 32'(exp_g[t]));
      step();
      chk("contend idle gap", 32'(av_write), 0);
      step();
    end
    req_write = 3'b000;
    step();

    // Wait states on requester 2
    set_req(2, 16'h1234, 16'h5678);
    req_write = 3'b100; av_waitrequest = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("ws addr stable", 32'(av_address), 32'h1234);
      chk("ws data stable", 32'(av_writedata), 32'h5678);
      chk("ws waitreq2 high", 32'(req_waitrequest[2]), 1);
      step();
    end
    av_waitrequest = 0;
    #1;
    chk("ws addr at completion", 32'(av_address), 32'h1234);
    chk("ws waitreq2 released", 32'(req_waitrequest[2]), 0);
    req_write = 3'b000;
    step();
    chk("ws done av_write", 32'(av_write), 0);

    // Requester drops req_write mid-transfer
    set_req(0, 16'h0100, 16'hAAAA);
    req_write = 3'b001; av_waitrequest = 1;
    step();
    req_write = 3'b000;
    set_req(0, 16'h0200, 16'h5555);
    step();
    chk("drop captured data", 32'(av_writedata), 32'hAAAA);
    chk("drop still writing", 32'(av_write), 1);
    av_waitrequest = 0;
    step();
    chk("drop done av_write", 32'(av_write), 0);
    chk("drop done busy", 32'(busy), 0);

    // Reset mid-transfer
    req_write = 3'b010; av_waitrequest = 1;
    step();
    chk("rstmid busy before", 32'(busy), 1);
    sysreset_n = 0;
    step();
    chk("rstmid av_write", 32'(av_write), 0);
    chk("rstmid busy", 32'(busy), 0);
    chk("rstmid grant_idx", 32'(grant_idx), 0);
    chk("rstmid av_address", 32'(av_address), 0);
    chk("rstmid av_writedata", 32'(av_writedata), 0);
    sysreset_n = 1; req_write = 3'b000; av_waitrequest = 0;
    step();

`ifdef AV_ARB_TIMEOUT_EN
    // Hung slave: abort after TO stalled cycles, then next requester granted
    req_write = 3'b001; av_waitrequest = 1;
    step();
    n = 0;
    while (av_write && n < 40) begin
      step();
      n++;
    end
    chk("to busy cycles", 32'(n), 32'(TO));
    chk("to err set", 32'(timeout_err), 1);
    req_write = 3'b011; av_waitrequest = 0;
    step();
    chk("to next grant", 32'(grant_idx), 1);
    req_write = 3'b000; timeout_clr = 1;
    step();
    timeout_clr = 0;
    chk("to err cleared", 32'(timeout_err), 0);
    step();
`endif

    // Randomized traffic
    stall_run = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_write = NR'($urandom);
      for (int i = 0; i < NR; i++) set_req(i, AW'($urandom), DW'($urandom));
      if (stall_run > 0) begin
        av_waitrequest = 1; stall_run--;
      end else begin
        av_waitrequest = ($urandom % 3 == 0);
        if ($urandom % 150 == 0) stall_run = 14;
      end
      timeout_clr = ($urandom % 20 == 0);
      sysreset_n  = ($urandom % 400 != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
